// File: rtl/timer_device_pkg.sv
// Shared encodings for the memory-mapped countdown timer: FSM states,
// register indices and CTRL bit positions.
package timer_device_pkg;

    typedef enum logic [1:0] {
        timerIDLE = 2'd0,
        timerLOAD = 2'd1,
        timerCNT  = 2'd2,
        timerINT  = 2'd3
    } timerState;

    localparam logic [1:0] timerCTRL   = 2'd0;
    localparam logic [1:0] timerPRESET = 2'd1;
    localparam logic [1:0] timerCOUNT  = 2'd2;

    localparam int ctrlEnableBit = 0;
    localparam int ctrlModeLo    = 1;
    localparam int ctrlModeHi    = 2;
    localparam int ctrlImBit     = 3;

    // Mode 1 auto-reloads; every other mode value is one-shot.
    localparam logic [1:0] modeAutoReload = 2'd1;

    localparam int prescalerWidth = 16;

endpackage

// File: rtl/timer_prescaler.sv
// Free-running divider: tick is high for one cycle every PRESCALE+1 cycles,
// with the phase restarted by clear.
module timer_prescaler
    import timer_device_pkg::*;
#(
    parameter int unsigned PRESCALE = 0
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic tick
);

    localparam logic [prescalerWidth-1:0] limit = prescalerWidth'(PRESCALE);

    logic [prescalerWidth-1:0] divCount;

    assign tick = (divCount == limit);

    // NOTE: sequential state is assigned with <= so every register samples
    // the pre-edge values of its neighbours, independent of statement order.
    always_ff @(posedge clk) begin
        if (!reset) begin
            divCount <= '0;
        end else if (clear || tick) begin
            divCount <= '0;
        end else begin
            divCount <= divCount + 1'b1;
        end
    end

endmodule

// File: rtl/timer_device.sv
// Programmable countdown timer on a word-addressed bus window; raises irq
// (one-shot sticky or auto-reload pulse) towards the CP0 interrupt inputs.
module timer_device
    import timer_device_pkg::*;
#(
    parameter int unsigned PRESCALE = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  addr,
    input  logic        writeEnable,
    input  logic [31:0] writeData,
    output logic [31:0] readData,
    output logic        irq
);

    timerState   state;
    timerState   nextState;
    logic        ctrlEnable;
    logic [1:0]  ctrlMode;
    logic        ctrlIm;
    logic [31:0] preset;
    logic [31:0] count;
    logic [31:0] countNext;
    logic        irqFlag;
    logic        flagSet;
    logic        enableClear;
    logic        loadPrescaler;
    logic        tick;
    logic        writeCtrl;
    logic        writePreset;

    assign writeCtrl   = writeEnable && (addr == timerCTRL);
    assign writePreset = writeEnable && (addr == timerPRESET);

    timer_prescaler #(
        .PRESCALE(PRESCALE)
    ) prescaler (
        .clk  (clk),
        .reset(reset),
        .clear(loadPrescaler),
        .tick (tick)
    );

    // NOTE: every output of this block gets a default first, so no path
    // through the case leaves a signal unassigned and no latch is inferred.
    always_comb begin
        nextState     = state;
        countNext     = count;
        loadPrescaler = 1'b0;
        enableClear   = 1'b0;
        flagSet       = 1'b0;
        case (state)
            timerIDLE: begin
                if (ctrlEnable) nextState = timerLOAD;
            end
            timerLOAD: begin
                countNext     = preset;
                loadPrescaler = 1'b1;
                nextState     = timerCNT;
            end
            timerCNT: begin
                if (!ctrlEnable) begin
                    nextState = timerIDLE;
                end else if (tick) begin
                    // A preset of 0 expires on the first tick, like a preset of 1.
                    if (count <= 32'd1) begin
                        countNext = '0;
                        nextState = timerINT;
                        flagSet   = (ctrlMode != modeAutoReload);
                    end else begin
                        countNext = count - 32'd1;
                    end
                end
            end
            timerINT: begin
                if (ctrlMode == modeAutoReload) begin
                    nextState = ctrlEnable ? timerLOAD : timerIDLE;
                end else begin
                    enableClear = 1'b1;
                    nextState   = timerIDLE;
                end
            end
            default: nextState = timerIDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= timerIDLE;
            count      <= '0;
            preset     <= '0;
            ctrlEnable <= 1'b0;
            ctrlMode   <= 2'd0;
            ctrlIm     <= 1'b0;
            irqFlag    <= 1'b0;
        end else begin
            state <= nextState;
            count <= countNext;
            // A CPU write to CTRL outranks the one-shot hardware Enable clear.
            if (writeCtrl) begin
                ctrlEnable <= writeData[ctrlEnableBit];
                ctrlMode   <= writeData[ctrlModeHi:ctrlModeLo];
                ctrlIm     <= writeData[ctrlImBit];
            end else if (enableClear) begin
                ctrlEnable <= 1'b0;
            end
            if (writePreset) preset <= writeData;
            if (flagSet) begin
                irqFlag <= 1'b1;
            end else if (writeCtrl || writePreset) begin
                irqFlag <= 1'b0;
            end
        end
    end

    always_comb begin
        readData = '0;
        case (addr)
            timerCTRL: begin
                readData[ctrlEnableBit]         = ctrlEnable;
                readData[ctrlModeHi:ctrlModeLo] = ctrlMode;
                readData[ctrlImBit]             = ctrlIm;
            end
            timerPRESET: readData = preset;
            timerCOUNT:  readData = count;
            default:     readData = '0;
        endcase
    end

    assign irq = ctrlIm & (irqFlag | ((state == timerINT) && (ctrlMode == modeAutoReload)));

endmodule
